// File: rtl/com_bus_arbiter_n.sv
// com_bus_arbiter_n
//   Common-bus arbiter and invalidation tracker for an N-core MESI system.
//   Proc requesters (DL 0..N-1, IL N..2N-1) share the bus round-robin with a
//   one-cycle turnaround after every release; DL snoop write-backs pre-empt
//   arbitration and may nest inside an active proc grant. A separate tracker
//   collects per-sharer invalidation acks with a bounded wait.
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   Com_Bus_Req_proc       [2N]  proc requests, held for the whole transaction
//   Com_Bus_Gnt_proc       [2N]  one-hot proc grant (registered)
//   Com_Bus_Req_snoop      [N]   DL snoop write-back requests
//   Com_Bus_Gnt_snoop      [N]   one-hot snoop grant (registered)
//   Invalidate             level invalidate from the bus owner
//   Shared_local           [N]   per-core "has copy" flags
//   Invalidation_done      [N]   per-core invalidation acks
//   All_Invalidation_done  all captured sharers acked, or timed out
//   Inv_timeout            one-cycle pulse on forced completion
//   Bus_owner              index of current/last proc owner
//   Bus_busy               proc grant or snoop grant active
module com_bus_arbiter_n #(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned INV_TIMEOUT = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [2*NUM_CORES-1:0]           Com_Bus_Req_proc,
    output logic [2*NUM_CORES-1:0]           Com_Bus_Gnt_proc,
    input  logic [NUM_CORES-1:0]             Com_Bus_Req_snoop,
    output logic [NUM_CORES-1:0]             Com_Bus_Gnt_snoop,
    input  logic                             Invalidate,
    input  logic [NUM_CORES-1:0]             Shared_local,
    input  logic [NUM_CORES-1:0]             Invalidation_done,
    output logic                             All_Invalidation_done,
    output logic                             Inv_timeout,
    output logic [$clog2(2*NUM_CORES)-1:0]   Bus_owner,
    output logic                             Bus_busy
);

    localparam int unsigned NC = NUM_CORES;
    localparam int unsigned NP = 2 * NUM_CORES;
    localparam int unsigned OW = $clog2(NP);
    localparam int unsigned CW = $clog2(INV_TIMEOUT);
    localparam logic [OW:0]   NP_EXT   = (OW+1)'(NP);
    localparam logic [OW-1:0] LAST_REQ = OW'(NP - 1);
    localparam logic [OW-1:0] NC_OW    = OW'(NC);
    localparam logic [CW-1:0] CNT_LAST = CW'(INV_TIMEOUT - 1);

    typedef enum logic [1:0] {P_IDLE, P_GRANT, P_RELEASE} p_state_e;
    typedef enum logic       {S_IDLE, S_GNT}              s_state_e;
    typedef enum logic [1:0] {I_IDLE, I_WAIT, I_DONE}     i_state_e;

    p_state_e       p_state_q, p_state_d;
    s_state_e       s_state_q, s_state_d;
    i_state_e       i_state_q, i_state_d;
    logic [NP-1:0]  gnt_p_q, gnt_p_d;
    logic [NC-1:0]  gnt_s_q, gnt_s_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [OW-1:0]  ptr_q, ptr_d;
    logic           busy_q, busy_d;
    logic [NC-1:0]  pend_q, pend_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           to_q, to_d;

    // Round-robin pick: rotate requests so bit 0 is the pointer position
    logic [2*NP-1:0] req_dbl;
    logic [NP-1:0]   req_rot;
    logic [OW-1:0]   rr_off;
    logic            rr_any;
    logic [OW:0]     rr_sum;
    logic [OW-1:0]   rr_win;

    always_comb begin
        req_dbl = {Com_Bus_Req_proc, Com_Bus_Req_proc} >> ptr_q;
        req_rot = req_dbl[NP-1:0];
        rr_off  = '0;
        rr_any  = 1'b0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (req_rot[i] && !rr_any) begin
                rr_off = OW'(i);
                rr_any = 1'b1;
            end
        end
        rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
        rr_win = (rr_sum >= NP_EXT) ? OW'(rr_sum - NP_EXT) : OW'(rr_sum);
    end

    // Lowest-index snoop requester, one-hot
    logic [NC-1:0] snp_pick;
    assign snp_pick = Com_Bus_Req_snoop & (~Com_Bus_Req_snoop + NC'(1));

    // Sharer mask excluding the owning core (DL and IL of a core share one index)
    logic [OW-1:0] owner_core;
    logic [NC-1:0] owner_mask;
    logic [NC-1:0] inv_capture;
    assign owner_core  = (owner_q >= NC_OW) ? (owner_q - NC_OW) : owner_q;
    assign owner_mask  = NC'(1) << owner_core;
    assign inv_capture = Shared_local & ~Invalidation_done & ~owner_mask;

    // Proc arbitration FSM
    always_comb begin
        p_state_d = p_state_q;
        gnt_p_d   = gnt_p_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        unique case (p_state_q)
            P_IDLE: begin
                // pending or newly arriving snoops take the bus first
                if (s_state_q == S_IDLE && !(|Com_Bus_Req_snoop) && rr_any) begin
                    p_state_d = P_GRANT;
                    gnt_p_d   = NP'(1) << rr_win;
                    owner_d   = rr_win;
                    ptr_d     = (rr_win == LAST_REQ) ? '0 : rr_win + OW'(1);
                end
            end
            P_GRANT: begin
                if (!(|(Com_Bus_Req_proc & gnt_p_q))) begin
                    p_state_d = P_RELEASE;
                    gnt_p_d   = '0;
                end
            end
            P_RELEASE: begin
                p_state_d = P_IDLE;
                gnt_p_d   = '0;
            end
            default: begin
                p_state_d = P_IDLE;
                gnt_p_d   = '0;
            end
        endcase
    end

    // Snoop write-back FSM; blocked only during proc turnaround
    always_comb begin
        s_state_d = s_state_q;
        gnt_s_d   = gnt_s_q;
        unique case (s_state_q)
            S_IDLE: begin
                if (|Com_Bus_Req_snoop && p_state_q != P_RELEASE) begin
                    s_state_d = S_GNT;
                    gnt_s_d   = snp_pick;
                end
            end
            S_GNT: begin
                if (!(|(Com_Bus_Req_snoop & gnt_s_q))) begin
                    s_state_d = S_IDLE;
                    gnt_s_d   = '0;
                end
            end
            default: begin
                s_state_d = S_IDLE;
                gnt_s_d   = '0;
            end
        endcase
        busy_d = (p_state_d == P_GRANT) || (s_state_d == S_GNT);
    end

    // Invalidation tracker FSM
    always_comb begin
        i_state_d = i_state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        to_d      = 1'b0;
        unique case (i_state_q)
            I_IDLE: begin
                if (Invalidate) begin
                    pend_d    = inv_capture;
                    cnt_d     = '0;
                    i_state_d = (inv_capture == '0) ? I_DONE : I_WAIT;
                end
            end
            I_WAIT: begin
                if (!Invalidate) begin
                    i_state_d = I_IDLE;
                    pend_d    = '0;
                    cnt_d     = '0;
                end else begin
                    pend_d = pend_q & ~Invalidation_done;
                    if (pend_d == '0) begin
                        i_state_d = I_DONE;
                        cnt_d     = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        i_state_d = I_DONE;
                        pend_d    = '0;
                        cnt_d     = '0;
                        to_d      = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            I_DONE: begin
                if (!Invalidate) begin
                    i_state_d = I_IDLE;
                    pend_d    = '0;
                end
            end
            default: begin
                i_state_d = I_IDLE;
                pend_d    = '0;
                cnt_d     = '0;
            end
        endcase
        done_d = (i_state_d == I_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q <= P_IDLE;
            s_state_q <= S_IDLE;
            i_state_q <= I_IDLE;
            gnt_p_q   <= '0;
            gnt_s_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            pend_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            s_state_q <= s_state_d;
            i_state_q <= i_state_d;
            gnt_p_q   <= gnt_p_d;
            gnt_s_q   <= gnt_s_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            to_q      <= to_d;
        end
    end

    assign Com_Bus_Gnt_proc      = gnt_p_q;
    assign Com_Bus_Gnt_snoop     = gnt_s_q;
    assign Bus_owner             = owner_q;
    assign Bus_busy              = busy_q;
    assign All_Invalidation_done = done_q;
    assign Inv_timeout           = to_q;

endmodule

// File: tb/tb_com_bus_arbiter_n.sv
// tb_com_bus_arbiter_n
//   Directed bench for com_bus_arbiter_n (NUM_CORES=4, INV_TIMEOUT=8) with a
//   behavioural reference model checked on every falling edge, plus literal
//   expectations at key points of each scenario.
module tb_com_bus_arbiter_n;

    localparam int NC = 4;
    localparam int NP = 8;
    localparam int TO = 8;

    logic          clk;
    logic          rst_n;
    logic [NP-1:0] preq;
    logic [NP-1:0] Com_Bus_Gnt_proc;
    logic [NC-1:0] sreq;
    logic [NC-1:0] Com_Bus_Gnt_snoop;
    logic          inv;
    logic [NC-1:0] shared;
    logic [NC-1:0] idone;
    logic          All_Invalidation_done;
    logic          Inv_timeout;
    logic [2:0]    Bus_owner;
    logic          Bus_busy;

    int errors = 0;
    int checks = 0;

    com_bus_arbiter_n #(.NUM_CORES(NC), .INV_TIMEOUT(TO)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .Com_Bus_Req_proc      (preq),
        .Com_Bus_Gnt_proc      (Com_Bus_Gnt_proc),
        .Com_Bus_Req_snoop     (sreq),
        .Com_Bus_Gnt_snoop     (Com_Bus_Gnt_snoop),
        .Invalidate            (inv),
        .Shared_local          (shared),
        .Invalidation_done     (idone),
        .All_Invalidation_done (All_Invalidation_done),
        .Inv_timeout           (Inv_timeout),
        .Bus_owner             (Bus_owner),
        .Bus_busy              (Bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the bus (-1 = nobody), turnaround flag,
    // invalidation phase 0=idle 1=waiting 2=done, outstanding sharer mask.
    int m_ph = -1, m_sh = -1, m_owner = 0, m_ptr = 0;
    bit m_turn = 0;
    int m_phase = 0, m_pend = 0, m_waited = 0;
    bit m_to = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int ph, sh, pick, old_owner;
        bit t;
        if (!rst_n) begin
            m_ph = -1; m_sh = -1; m_owner = 0; m_ptr = 0; m_turn = 0;
            m_phase = 0; m_pend = 0; m_waited = 0; m_to = 0;
        end else begin
            ph = m_ph; sh = m_sh; t = m_turn; old_owner = m_owner;
            // snoop holder
            if (sh >= 0) begin
                if (!sreq[sh]) m_sh = -1;
            end else if (sreq != 0 && !t) begin
                pick = -1;
                for (int i = NC - 1; i >= 0; i--) if (sreq[i]) pick = i;
                m_sh = pick;
            end
            // proc holder
            m_turn = 0;
            if (t) begin
                m_ph = -1;
            end else if (ph >= 0) begin
                if (!preq[ph]) begin m_ph = -1; m_turn = 1; end
            end else if (sh < 0 && sreq == 0 && preq != 0) begin
                pick = -1;
                for (int j = 0; j < NP; j++)
                    if (pick < 0 && preq[(m_ptr + j) % NP]) pick = (m_ptr + j) % NP;
                m_ph = pick; m_owner = pick; m_ptr = (pick + 1) % NP;
            end
            // invalidation
            m_to = 0;
            case (m_phase)
                0: if (inv) begin
                    m_pend   = int'(shared & ~idone) & ~(1 << (old_owner % NC));
                    m_waited = 0;
                    m_phase  = (m_pend == 0) ? 2 : 1;
                end
                1: if (!inv) begin
                    m_phase = 0; m_pend = 0;
                end else begin
                    m_waited++;
                    m_pend = m_pend & ~int'(idone);
                    if (m_pend == 0) m_phase = 2;
                    else if (m_waited >= TO) begin m_phase = 2; m_to = 1; m_pend = 0; end
                end
                default: if (!inv) m_phase = 0;
            endcase
        end
    end

    // Compare DUT against model on every falling edge
    always @(negedge clk) begin : compare
        logic [NP-1:0] egp;
        logic [NC-1:0] egs;
        egp = '0; egs = '0;
        if (m_ph >= 0) egp[m_ph] = 1'b1;
        if (m_sh >= 0) egs[m_sh] = 1'b1;
        check("m_gnt_proc", 32'(Com_Bus_Gnt_proc), 32'(egp));
        check("m_gnt_snoop", 32'(Com_Bus_Gnt_snoop), 32'(egs));
        check("m_owner", 32'(Bus_owner), 32'(m_owner));
        check("m_busy", 32'(Bus_busy), 32'((m_ph >= 0) || (m_sh >= 0)));
        check("m_all_done", 32'(All_Invalidation_done), 32'(m_phase == 2));
        check("m_timeout", 32'(Inv_timeout), 32'(m_to));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        preq = '0; sreq = '0; inv = 1'b0; shared = '0; idone = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        preq = 8'h05; sreq = '0; inv = 1'b0; shared = '0; idone = '0;
        @(posedge clk); #1;
        check("rst_gnt_proc", 32'(Com_Bus_Gnt_proc), 32'h0);
        check("rst_owner", 32'(Bus_owner), 32'h0);
        check("rst_busy", 32'(Bus_busy), 32'h0);
        check("rst_done", 32'(All_Invalidation_done), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // DL0 and DL2 held from reset
        cyc(1);
        check("dl0_gnt", 32'(Com_Bus_Gnt_proc), 32'h01);
        check("dl0_busy", 32'(Bus_busy), 32'h1);
        preq = 8'h04;
        cyc(1);
        check("turnaround", 32'(Com_Bus_Gnt_proc), 32'h00);
        cyc(2);
        check("dl2_gnt", 32'(Com_Bus_Gnt_proc), 32'h04);
        check("dl2_owner", 32'(Bus_owner), 32'h2);
        preq = '0;
        cyc(2);

        // Full round robin with wrap
        do_reset();
        preq = 8'hFF;
        for (int k = 0; k <= NP; k++) begin
            logic [NP-1:0] want;
            want = '0;
            want[k % NP] = 1'b1;
            cyc(1);
            check("rr_gnt", 32'(Com_Bus_Gnt_proc), 32'(want));
            check("rr_owner", 32'(Bus_owner), 32'(k % NP));
            cyc(1);
            preq[k % NP] = 1'b0;
            cyc(1);
            check("rr_gap", 32'(Com_Bus_Gnt_proc), 32'h0);
            preq = (k == NP) ? 8'h00 : 8'hFF;
            cyc(1);
        end

        // Snoop nested inside a DL1 proc grant
        preq = 8'h02;
        cyc(1);
        check("dl1_gnt", 32'(Com_Bus_Gnt_proc), 32'h02);
        sreq = 4'h8;
        cyc(1);
        check("snp_gnt", 32'(Com_Bus_Gnt_snoop), 32'h8);
        check("snp_proc_hold", 32'(Com_Bus_Gnt_proc), 32'h02);
        sreq = 4'h0;
        cyc(1);
        check("snp_rel", 32'(Com_Bus_Gnt_snoop), 32'h0);
        check("snp_proc_kept", 32'(Com_Bus_Gnt_proc), 32'h02);
        preq = '0;
        cyc(2);

        // Make DL0 the owner, then invalidate with all sharers
        preq = 8'h01;
        cyc(1);
        check("dl0_owner", 32'(Bus_owner), 32'h0);
        preq = '0;
        cyc(2);
        shared = 4'hF; inv = 1'b1;
        cyc(1);
        check("inv_wait", 32'(All_Invalidation_done), 32'h0);
        idone = 4'h4; cyc(1);
        idone = 4'h2; cyc(1);
        check("inv_partial", 32'(All_Invalidation_done), 32'h0);
        idone = 4'h8; cyc(1);
        idone = 4'h0;
        check("inv_all_done", 32'(All_Invalidation_done), 32'h1);
        cyc(1);
        check("inv_done_hold", 32'(All_Invalidation_done), 32'h1);
        inv = 1'b0;
        cyc(1);
        check("inv_done_fall", 32'(All_Invalidation_done), 32'h0);
        shared = '0;
        cyc(1);

        // Core1 never acks -> timeout after 8 waiting cycles
        shared = 4'h3; inv = 1'b1;
        cyc(1);
        cyc(7);
        check("to_not_yet", 32'(Inv_timeout), 32'h0);
        check("to_done_not_yet", 32'(All_Invalidation_done), 32'h0);
        cyc(1);
        check("to_pulse", 32'(Inv_timeout), 32'h1);
        check("to_done", 32'(All_Invalidation_done), 32'h1);
        cyc(1);
        check("to_pulse_end", 32'(Inv_timeout), 32'h0);
        inv = 1'b0;
        cyc(1);

        // Same again, reset asserted mid-wait with a proc grant active
        preq = 8'h01; shared = 4'h3; inv = 1'b1;
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(Com_Bus_Gnt_proc), 32'h0);
        check("arst_busy", 32'(Bus_busy), 32'h0);
        check("arst_owner", 32'(Bus_owner), 32'h0);
        check("arst_done", 32'(All_Invalidation_done), 32'h0);
        check("arst_to", 32'(Inv_timeout), 32'h0);
        preq = '0; inv = 1'b0; shared = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1);

        // Snoop and proc request arriving together: snoop first
        preq = 8'h01; sreq = 4'h2;
        cyc(1);
        check("tie_snp", 32'(Com_Bus_Gnt_snoop), 32'h2);
        check("tie_proc_wait", 32'(Com_Bus_Gnt_proc), 32'h0);
        sreq = 4'h0;
        cyc(2);
        check("tie_proc_late", 32'(Com_Bus_Gnt_proc), 32'h01);
        preq = '0;
        cyc(2);

        // Owner DL2 is the only sharer -> nothing to wait for
        preq = 8'h04;
        cyc(1);
        check("dl2b_owner", 32'(Bus_owner), 32'h2);
        preq = '0;
        cyc(2);
        shared = 4'h4; inv = 1'b1;
        cyc(2);
        check("self_only_done", 32'(All_Invalidation_done), 32'h1);
        check("self_only_no_to", 32'(Inv_timeout), 32'h0);
        inv = 1'b0;
        cyc(1);
        check("self_only_fall", 32'(All_Invalidation_done), 32'h0);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
